// File: rtl/grant_decoder_seq_if.sv
// Grant bus between a priority encoder/requester group (master) and grant_decoder_seq (slave).
// ENC/VLD is a valid-only offer; the decoder takes it on any edge it is IDLE, otherwise VLD is ignored.
interface grant_decoder_seq_if #(
    parameter int ENC_W = 2,
    parameter int CNT_W = 8
);
    localparam int N = 2 ** ENC_W;

    logic [ENC_W-1:0] ENC;
    logic             VLD;
    logic             ACK;
    logic [N-1:0]     GNT;
    logic [ENC_W-1:0] IDX;
    logic             BUSY;
    logic             ERR;
    logic [CNT_W-1:0] GCNT;
    logic [1:0]       dbg_state;

    modport master (
        output ENC, VLD, ACK,
        input  GNT, IDX, BUSY, ERR, GCNT, dbg_state
    );

    modport slave (
        input  ENC, VLD, ACK,
        output GNT, IDX, BUSY, ERR, GCNT, dbg_state
    );
endinterface

// File: rtl/grant_decoder_seq.sv
// Captures an encoded request, drives a one-hot grant until ACK or timeout,
// then cools down before accepting the next request. Counts ACKed grants.
module grant_decoder_seq #(
    parameter int ENC_W    = 2,
    parameter int HOLD_CYC = 3,
    parameter int TIMEOUT  = 8,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    grant_decoder_seq_if.slave   bus
);
    localparam int N         = 2 ** ENC_W;
    localparam int TMR_MAX   = (TIMEOUT > HOLD_CYC) ? TIMEOUT : HOLD_CYC;
    localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int HOLD_LAST = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        COOL     = 2'd2
    } state_t;

    // With no cooldown the grant ends straight back in IDLE.
    localparam state_t POST_GRANT = (HOLD_CYC == 0) ? IDLE : COOL;
    localparam logic   POST_BUSY  = (HOLD_CYC != 0);
    localparam logic [N-1:0] ONE_HOT0 = N'(1);

    state_t           state_q;
    logic [TMR_W-1:0] tmr_q;
    logic [N-1:0]     gnt_q;
    logic [ENC_W-1:0] idx_q;
    logic             busy_q;
    logic             err_q;
    logic [CNT_W-1:0] gcnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            gcnt_q  <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.VLD) begin
                        idx_q   <= bus.ENC;
                        gnt_q   <= ONE_HOT0 << bus.ENC;
                        tmr_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // ACK takes precedence over a coincident timeout.
                    if (bus.ACK) begin
                        gnt_q   <= '0;
                        gcnt_q  <= gcnt_q + CNT_W'(1);
                        tmr_q   <= '0;
                        busy_q  <= POST_BUSY;
                        state_q <= POST_GRANT;
                    end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                        gnt_q   <= '0;
                        err_q   <= 1'b1;
                        tmr_q   <= '0;
                        busy_q  <= POST_BUSY;
                        state_q <= POST_GRANT;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                COOL: begin
                    if (tmr_q == TMR_W'(HOLD_LAST)) begin
                        tmr_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                default: begin
                    tmr_q   <= '0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.GNT       = gnt_q;
    assign bus.IDX       = idx_q;
    assign bus.BUSY      = busy_q;
    assign bus.ERR       = err_q;
    assign bus.GCNT      = gcnt_q;
    assign bus.dbg_state = state_q;
endmodule
